// File: rtl/tick_timer_ctrl.sv
// Tick timer controller: a free-running prescaler produces a periodic tick, and four
// one-shot/periodic channels are serviced in turn after each tick by one shared decrementer.
module tick_timer_ctrl #(
    parameter int unsigned TICK_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_ch,
    input  logic        cfg_start,
    input  logic        cfg_mode,
    input  logic [15:0] cfg_period,
    input  logic [3:0]  irq_ack,
    output logic        tick,
    output logic [3:0]  ch_active,
    output logic [3:0]  ch_expire,
    output logic [3:0]  pending,
    output logic        irq
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned PER_W  = 16;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN0 = 3'd1,
        SCAN1 = 3'd2,
        SCAN2 = 3'd3,
        SCAN3 = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  presc;
    logic [PER_W-1:0]  period    [NUM_CH];
    logic [PER_W-1:0]  remaining [NUM_CH];
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] active;

    logic              svc_en;
    logic [CH_W-1:0]   svc_ch;
    logic [PER_W-1:0]  svc_rem;
    logic [PER_W-1:0]  svc_dec;
    logic              svc_last;
    logic              cfg_xfer;
    logic              cfg_load;

    // Tick is registered one cycle early so it coincides with the counter's last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= (presc == CNT_LAST) ? '0 : presc + CNT_W'(1);
            tick  <= (presc == CNT_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (tick) state <= SCAN0;
                SCAN0:   state <= SCAN1;
                SCAN1:   state <= SCAN2;
                SCAN2:   state <= SCAN3;
                SCAN3:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Scan state selects the channel fed through the shared decrementer.
    always_comb begin
        svc_en = 1'b1;
        svc_ch = CH_W'(0);
        case (state)
            SCAN0:   svc_ch = CH_W'(0);
            SCAN1:   svc_ch = CH_W'(1);
            SCAN2:   svc_ch = CH_W'(2);
            SCAN3:   svc_ch = CH_W'(3);
            default: svc_en = 1'b0;
        endcase
    end

    assign svc_rem  = remaining[svc_ch];
    assign svc_dec  = svc_rem - PER_W'(1);
    assign svc_last = (svc_rem == PER_W'(1));

    // Configuration is only taken while no scan is running or about to start.
    assign cfg_ready = (state == IDLE) && !tick && !rst;
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign cfg_load  = cfg_start && (cfg_period != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period[i]    <= '0;
                remaining[i] <= '0;
            end
            mode      <= '0;
            active    <= '0;
            ch_expire <= '0;
        end else begin
            ch_expire <= '0;
            if (svc_en && active[svc_ch]) begin
                if (svc_last) begin
                    ch_expire[svc_ch] <= 1'b1;
                    if (mode[svc_ch]) begin
                        remaining[svc_ch] <= period[svc_ch];
                    end else begin
                        remaining[svc_ch] <= '0;
                        active[svc_ch]    <= 1'b0;
                    end
                end else if (svc_rem != '0) begin
                    remaining[svc_ch] <= svc_dec;
                end
            end
            if (cfg_xfer) begin
                if (cfg_load) begin
                    period[cfg_ch]    <= cfg_period;
                    remaining[cfg_ch] <= cfg_period;
                    mode[cfg_ch]      <= cfg_mode;
                    active[cfg_ch]    <= 1'b1;
                end else begin
                    remaining[cfg_ch] <= '0;
                    active[cfg_ch]    <= 1'b0;
                end
            end
        end
    end

    // A fresh expiry takes priority over an acknowledge in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~irq_ack) | ch_expire;
        end
    end

    assign ch_active = active;
    assign irq       = |pending;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Bench for tick_timer_ctrl: directed scenarios followed by random configuration,
// acknowledge and reset traffic, all checked every cycle against a tick-level model.
module tb_tick_timer_ctrl;

    localparam int unsigned D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic        cfg_start;
    logic        cfg_mode;
    logic [15:0] cfg_period;
    logic [3:0]  irq_ack;
    logic        tick;
    logic [3:0]  ch_active;
    logic [3:0]  ch_expire;
    logic [3:0]  pending;
    logic        irq;

    tick_timer_ctrl #(.TICK_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_start  (cfg_start),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .irq_ack    (irq_ack),
        .tick       (tick),
        .ch_active  (ch_active),
        .ch_expire  (ch_expire),
        .pending    (pending),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic        start;
        logic        mode;
        logic [15:0] per;
    } req_t;

    req_t       rq[$];
    int         n_cmp;
    int         n_err;
    int         cyc;
    int         m_per  [4];
    int         m_rem  [4];
    bit         m_mode [4];
    bit         m_act  [4];
    int         ev_at  [4];
    bit         ev_val [4];
    int         exp_at [4];
    int         seen_exp [4];
    logic [3:0] vis_act;
    logic [3:0] pend;
    logic [3:0] prev_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_per[k]  = 0;
            m_rem[k]  = 0;
            m_mode[k] = 1'b0;
            m_act[k]  = 1'b0;
            ev_at[k]  = -100;
            ev_val[k] = 1'b0;
            exp_at[k] = -100;
        end
        vis_act = '0;
        pend    = '0;
        cyc     = 0;
    endfunction

    function automatic logic [3:0] exp_now();
        logic [3:0] e;
        e = '0;
        for (int k = 0; k < 4; k++) e[k] = (exp_at[k] == cyc);
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t q;
        int   sel;
        q.ch    = 2'($urandom);
        q.start = ($urandom_range(0, 4) != 0);
        q.mode  = 1'($urandom);
        sel     = $urandom_range(0, 9);
        if (sel == 0)      q.per = 16'h0000;
        else if (sel == 1) q.per = 16'hFFFF;
        else               q.per = 16'($urandom_range(1, 6));
        return q;
    endfunction

    // One clock cycle: drive, check against the model, then advance the model past the edge.
    task automatic run_cycle(input logic r, input logic [3:0] ack);
        logic       tick_e;
        logic       ready_e;
        logic [3:0] exp_e;
        req_t       q;
        int         ph;
        for (int k = 0; k < 4; k++) if (ev_at[k] == cyc) vis_act[k] = ev_val[k];
        ph      = cyc % D;
        tick_e  = (ph == D - 1);
        ready_e = !r && !tick_e && !(cyc >= D && ph <= 3);
        exp_e   = exp_now();

        rst     = r;
        irq_ack = ack;
        if (rq.size() > 0) begin
            cfg_valid  = 1'b1;
            cfg_ch     = rq[0].ch;
            cfg_start  = rq[0].start;
            cfg_mode   = rq[0].mode;
            cfg_period = rq[0].per;
        end else begin
            cfg_valid  = 1'b0;
            cfg_ch     = 2'($urandom);
            cfg_start  = 1'($urandom);
            cfg_mode   = 1'($urandom);
            cfg_period = 16'($urandom);
        end
        #1;
        check_eq("tick",      32'(tick),      32'(tick_e));
        check_eq("cfg_ready", 32'(cfg_ready), 32'(ready_e));
        check_eq("ch_active", 32'(ch_active), 32'(vis_act));
        check_eq("ch_expire", 32'(ch_expire), 32'(exp_e));
        check_eq("pending",   32'(pending),   32'(pend));
        check_eq("irq",       32'(irq),       32'(|pend));
        for (int k = 0; k < 4; k++) seen_exp[k] += int'(ch_expire[k]);
        prev_exp = exp_e;

        if (r) begin
            model_reset();
        end else begin
            pend = (pend & ~ack) | exp_e;
            if (tick_e) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_act[k]) begin
                        if (m_rem[k] > 1) begin
                            m_rem[k]--;
                        end else begin
                            exp_at[k] = cyc + 2 + k;
                            if (m_mode[k]) begin
                                m_rem[k] = m_per[k];
                            end else begin
                                m_rem[k]  = 0;
                                m_act[k]  = 1'b0;
                                ev_at[k]  = cyc + 2 + k;
                                ev_val[k] = 1'b0;
                            end
                        end
                    end
                end
            end
            if (cfg_valid && ready_e) begin
                q = rq.pop_front();
                if (q.start && q.per != 16'h0) begin
                    m_per[q.ch]  = int'(q.per);
                    m_rem[q.ch]  = int'(q.per);
                    m_mode[q.ch] = q.mode;
                    m_act[q.ch]  = 1'b1;
                    ev_val[q.ch] = 1'b1;
                end else begin
                    m_rem[q.ch]  = 0;
                    m_act[q.ch]  = 1'b0;
                    ev_val[q.ch] = 1'b0;
                end
                ev_at[q.ch] = cyc + 1;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic void clear_seen();
        for (int k = 0; k < 4; k++) seen_exp[k] = 0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic seen_tick;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_start = 1'b0;
        cfg_mode = 1'b0; cfg_period = '0; irq_ack = '0;
        n_cmp = 0; n_err = 0; prev_exp = '0;
        clear_seen();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        run_cycle(1'b1, 4'h0);
        run_cycle(1'b1, 4'h0);

        // Quiet run: only ticks should appear.
        repeat (30) run_cycle(1'b0, 4'h0);

        // One-shot on channel 2, period 3.
        clear_seen();
        rq.push_back('{2'd2, 1'b1, 1'b0, 16'd3});
        repeat (50) run_cycle(1'b0, 4'h0);
        check_eq("ch2_oneshot_count", 32'(seen_exp[2]), 32'd1);
        check_eq("ch2_pending_held",  32'(pending[2]),  32'd1);
        run_cycle(1'b0, 4'b0100);
        check_eq("ch2_after_ack", 32'({irq, pending[2], ch_active[2]}), 32'd0);

        // Periodic channels 0 (period 2) and 3 (period 1).
        clear_seen();
        rq.push_back('{2'd0, 1'b1, 1'b1, 16'd2});
        rq.push_back('{2'd3, 1'b1, 1'b1, 16'd1});
        repeat (60) run_cycle(1'b0, 4'($urandom));
        check_eq("periodic_active", 32'({ch_active[3], ch_active[0]}), 32'h3);
        check_eq("ch3_every_tick", 32'(seen_exp[3] >= 6), 32'd1);

        // Channel 1 acknowledged in its expiry cycle and again the cycle after.
        rq.push_back('{2'd1, 1'b1, 1'b1, 16'd2});
        for (int i = 0; i < 48; i++) run_cycle(1'b0, (exp_now() | prev_exp) & 4'b0010);

        // Back-to-back requests held valid across scan windows.
        rq.push_back('{2'd0, 1'b0, 1'b1, 16'd5});
        rq.push_back('{2'd3, 1'b1, 1'b1, 16'd0});
        rq.push_back('{2'd1, 1'b0, 1'b0, 16'd9});
        for (int i = 0; i < 6; i++) rq.push_back(rand_req());
        for (int i = 0; i < 60 && rq.size() > 0; i++) run_cycle(1'b0, 4'h0);
        check_eq("burst_drained", 32'(rq.size()), 32'd0);
        repeat (20) run_cycle(1'b0, 4'hF);

        // Reset in the middle of a scan with channels 1 and 2 about to expire.
        rq.push_back('{2'd1, 1'b1, 1'b0, 16'd1});
        rq.push_back('{2'd2, 1'b1, 1'b0, 16'd1});
        for (int i = 0; i < 20 && rq.size() > 0; i++) run_cycle(1'b0, 4'h0);
        found = 1'b0;
        seen_tick = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (seen_tick && (cyc % D) == 1) begin
                found = 1'b1;
            end else begin
                if ((cyc % D) == D - 1) seen_tick = 1'b1;
                run_cycle(1'b0, 4'h0);
            end
        end
        check_eq("scan1_reached", 32'(found), 32'd1);
        run_cycle(1'b1, 4'h0);
        check_eq("post_rst_outputs", 32'({tick, ch_active, ch_expire, pending, irq}), 32'd0);
        repeat (20) run_cycle(1'b0, 4'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [3:0] ack;
            if (rq.size() == 0 && $urandom_range(0, 9) == 0) rq.push_back(rand_req());
            r   = ($urandom_range(0, 399) == 0);
            ack = 4'($urandom) & 4'($urandom);
            run_cycle(r, ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
